// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, port ids,
// counter widths and the default starvation/lock limits.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam int STARVE_MAX_DEF = 4;
  localparam int LOCK_MAX_DEF   = 8;

  // Widths cover the legal ranges 1..15 and 1..255.
  localparam int STARVE_CNT_W = 4;
  localparam int LOCK_CNT_W   = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the single-port memory command.
// master = requesters plus memory (environment side), slave = the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_stall;

  logic              p1_req;
  logic              p1_we;
  logic              p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_stall,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_stall,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selector. Tie policy is fixed p0 priority by default;
// defining DMEM_ARB_RR_EN switches ties to round-robin on the last owner.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic  p0_req,
  input  logic  p1_req,
  input  port_e last_owner,
  input  logic  owner_valid,
  input  logic  lock_hold,
  input  logic  force_p0,
  input  logic  starve,
  output logic  gnt0,
  output logic  gnt1
);

  logic tie_p0;

`ifdef DMEM_ARB_RR_EN
  assign tie_p0 = !owner_valid || (last_owner == PORT1);
`else
  logic unused_owner;
  assign unused_owner = &{1'b0, owner_valid, last_owner};
  assign tie_p0       = 1'b1;
`endif

  // Precedence on a tie: active lock, post-lock p0 turn, starvation, policy.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_hold) begin
      gnt1 = 1'b1;
    end else if (p0_req && p1_req) begin
      if (force_p0)    gnt0 = 1'b1;
      else if (starve) gnt1 = 1'b1;
      else if (tie_p0) gnt0 = 1'b1;
      else             gnt1 = 1'b1;
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (p0) vs DMA/debug (p1) with burst lock and
// starvation guard. Optional round-robin tie policy via DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [LOCK_CNT_W-1:0]   LOCK_LIM   = LOCK_CNT_W'(LOCK_MAX);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic [LOCK_CNT_W-1:0]   lock_q, lock_d, lock_inc;
  logic                    force_p0_q, force_p0_d;
  logic                    rv0_q, rv0_d, rv1_q, rv1_d;

  logic        pick_gnt0, pick_gnt1, gnt0, gnt1;
  logic        lock_hold, starve, owner_valid;
  port_e       last_owner;
  logic              mem_we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign lock_hold   = (state_q == ST_LOCK1) && bus.p1_req && bus.p1_lock;
  assign starve      = (starve_q == STARVE_LIM) && bus.p1_req;
  assign owner_valid = (state_q != ST_IDLE);
  assign last_owner  = (state_q == ST_OWN0) ? PORT0 : PORT1;
  assign lock_inc    = (state_q == ST_LOCK1) ? lock_q + 1'b1 : LOCK_CNT_W'(1);

  dmem_arb_pick u_pick (
    .p0_req     (bus.p0_req),
    .p1_req     (bus.p1_req),
    .last_owner (last_owner),
    .owner_valid(owner_valid),
    .lock_hold  (lock_hold),
    .force_p0   (force_p0_q),
    .starve     (starve),
    .gnt0       (pick_gnt0),
    .gnt1       (pick_gnt1)
  );

  // Grants are combinational, so they are masked while reset is held.
  assign gnt0 = pick_gnt0 & ~rst;
  assign gnt1 = pick_gnt1 & ~rst;

  always_comb begin
    mem_we_mux = 1'b0;
    addr_mux   = '0;
    wdata_mux  = '0;
    if (gnt0) begin
      mem_we_mux = bus.p0_we;
      addr_mux   = bus.p0_addr;
      wdata_mux  = bus.p0_wdata;
    end else if (gnt1) begin
      mem_we_mux = bus.p1_we;
      addr_mux   = bus.p1_addr;
      wdata_mux  = bus.p1_wdata;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_stall  = bus.p0_req & ~gnt0 & ~rst;
  assign bus.mem_req   = gnt0 | gnt1;
  assign bus.mem_we    = mem_we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.p0_rvalid = rv0_q;
  assign bus.p1_rvalid = rv1_q;
  assign bus.p0_rdata  = rv0_q ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = rv1_q ? bus.mem_rdata : '0;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    lock_d     = lock_q;
    force_p0_d = 1'b0;
    rv0_d      = gnt0 & ~bus.p0_we;
    rv1_d      = gnt1 & ~bus.p1_we;
    if (gnt1) begin
      starve_d = '0;
      if (bus.p1_lock) begin
        // Hitting the beat limit ends the burst and hands p0 the next cycle.
        if (lock_inc == LOCK_LIM) begin
          state_d    = ST_OWN1;
          lock_d     = '0;
          force_p0_d = 1'b1;
        end else begin
          state_d = ST_LOCK1;
          lock_d  = lock_inc;
        end
      end else begin
        state_d = ST_OWN1;
        lock_d  = '0;
      end
    end else if (gnt0) begin
      state_d = ST_OWN0;
      lock_d  = '0;
      if (!bus.p1_req)                starve_d = '0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    end else if (state_q == ST_LOCK1) begin
      state_d = ST_OWN1;
      lock_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      lock_q     <= '0;
      force_p0_q <= 1'b0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lock_q     <= lock_d;
      force_p0_q <= force_p0_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (STARVE_MAX=4, LOCK_MAX=8); the tie-policy
// scenario follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .LOCK_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
    bus.p1_addr = '0;  bus.p1_wdata = '0;
    bus.mem_rdata = 32'hA5A5_A5A5;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    rst = 1'b1;
    clear_inputs();
    bus.p0_req = 1'b1; bus.p1_req = 1'b1; bus.p1_addr = 32'h44;
    next_cycle(); #2;
    ctl = {bus.p0_gnt, bus.p1_gnt, bus.mem_req, bus.mem_we, bus.p0_stall, bus.p0_rvalid, bus.p1_rvalid};
    n_cmp++;
    if (ctl !== 7'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0); end
    n_cmp++;
    if ({bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_req} !== 3'b101) begin
      n_bad++; $display("FAIL first_grant: got %b want %b", {bus.p0_gnt, bus.p1_gnt, bus.mem_req}, 3'b101);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h10;
    #2;
    n_cmp++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.mem_req, bus.mem_we, bus.p0_stall} !== 5'b10100) begin
      n_bad++; $display("FAIL read_gnt: got %b want %b", {bus.p0_gnt, bus.p1_gnt, bus.mem_req, bus.mem_we, bus.p0_stall}, 5'b10100);
    end
    n_cmp++;
    if (bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL read_addr: got %h want %h", bus.mem_addr, 32'h10); end
    next_cycle();
    clear_inputs();
    bus.mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++;
    if ({bus.p0_rvalid, bus.p1_rvalid, bus.mem_req} !== 3'b100) begin
      n_bad++; $display("FAIL read_rvalid: got %b want %b", {bus.p0_rvalid, bus.p1_rvalid, bus.mem_req}, 3'b100);
    end
    n_cmp++;
    if (bus.p0_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_data: got %h want %h", bus.p0_rdata, 32'hDEAD_BEEF); end
    next_cycle(); #2;
    n_cmp++;
    if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL read_rvalid_drop: got %b want %b", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h20; bus.p0_wdata = 32'h55;
    #2;
    n_cmp++;
    if ({bus.p0_gnt, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 32'h20, 32'h55}) begin
      n_bad++; $display("FAIL b2b_write: got %b %h %h want 111 20 55", {bus.p0_gnt, bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    next_cycle();
    bus.p0_we = 1'b0;
    #2;
    n_cmp++;
    if ({bus.p0_gnt, bus.mem_req, bus.mem_we, bus.p0_rvalid} !== 4'b1100) begin
      n_bad++; $display("FAIL b2b_read: got %b want %b", {bus.p0_gnt, bus.mem_req, bus.mem_we, bus.p0_rvalid}, 4'b1100);
    end
    next_cycle();
    clear_inputs();
    bus.mem_rdata = 32'h55;
    #2;
    n_cmp++;
    if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 32'h55}) begin
      n_bad++; $display("FAIL b2b_rdata: got %b %h want 1 55", bus.p0_rvalid, bus.p0_rdata);
    end
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_policy();
    logic p1_exp;
    apply_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h40;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      p1_exp = (i % 2) == 1;
      #2;
      n_cmp++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p0_stall} !== {!p1_exp, p1_exp, p1_exp}) begin
        n_bad++; $display("FAIL rr_cycle%0d: got %b want %b", i, {bus.p0_gnt, bus.p1_gnt, bus.p0_stall}, {!p1_exp, p1_exp, p1_exp});
      end
      next_cycle();
    end
    clear_inputs();
  endtask
`else
  task automatic test_policy();
    logic p1_exp, rv_exp;
    apply_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h40;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h80;
    for (int i = 0; i < 15; i++) begin
      p1_exp = (i % 5) == 4;
      rv_exp = (i % 5) == 0 && i != 0;
      #2;
      n_cmp++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p0_stall, bus.p1_rvalid} !== {!p1_exp, p1_exp, p1_exp, rv_exp}) begin
        n_bad++; $display("FAIL starve_cycle%0d: got %b want %b", i, {bus.p0_gnt, bus.p1_gnt, bus.p0_stall, bus.p1_rvalid}, {!p1_exp, p1_exp, p1_exp, rv_exp});
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_idle_hold();
    logic p1_exp;
    apply_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p1_req = 1'b1; bus.p1_we = 1'b1;
    next_cycle();
    next_cycle();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.p0_gnt, bus.p1_gnt} !== 4'b0) begin
        n_bad++; $display("FAIL idle_cycle%0d: got %b want 0000", i, {bus.mem_req, bus.mem_we, bus.p0_gnt, bus.p1_gnt});
      end
      next_cycle();
    end
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p1_req = 1'b1; bus.p1_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p1_exp = (i == 2);
      #2;
      n_cmp++;
      if ({bus.p0_gnt, bus.p1_gnt} !== {!p1_exp, p1_exp}) begin
        n_bad++; $display("FAIL hold_resume%0d: got %b want %b", i, {bus.p0_gnt, bus.p1_gnt}, {!p1_exp, p1_exp});
      end
      next_cycle();
    end
    clear_inputs();
  endtask
`endif

  task automatic test_lock_burst();
    int          beat;
    logic        p0_exp, stall_exp;
    logic [31:0] addr_exp;
    apply_reset();
    beat = 0;
    bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_we = 1'b1;
    bus.p1_addr = 32'h100; bus.p1_wdata = 32'h0;
    for (int c = 0; c < 11; c++) begin
      if (c == 1) begin
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h40; bus.p0_wdata = 32'h77;
      end
      p0_exp    = (c == 8);
      stall_exp = (c >= 1 && c < 8);
      addr_exp  = p0_exp ? 32'h40 : 32'h100 + 32'(4 * beat);
      #2;
      n_cmp++;
      if ({bus.p0_gnt, bus.p1_gnt, bus.p0_stall, bus.mem_addr} !== {p0_exp, !p0_exp, stall_exp, addr_exp}) begin
        n_bad++; $display("FAIL lock_cycle%0d: got %b %h want %b %h", c, {bus.p0_gnt, bus.p1_gnt, bus.p0_stall}, bus.mem_addr, {p0_exp, !p0_exp, stall_exp}, addr_exp);
      end
      next_cycle();
      if (p0_exp) bus.p0_req = 1'b0;
      else        beat++;
      bus.p1_addr  = 32'h100 + 32'(4 * beat);
      bus.p1_wdata = 32'(beat);
    end
    clear_inputs();
    #2;
    n_cmp++;
    if ({bus.mem_req, bus.p0_gnt, bus.p1_gnt} !== 3'b000) begin
      n_bad++; $display("FAIL lock_done: got %b want 000", {bus.mem_req, bus.p0_gnt, bus.p1_gnt});
    end
  endtask

  task automatic test_reset_discard();
    logic [6:0] ctl;
    apply_reset();
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h84;
    #2;
    n_cmp++;
    if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL discard_gnt: got %b want 01", {bus.p0_gnt, bus.p1_gnt});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.p0_req = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #2;
    ctl = {bus.p0_gnt, bus.p1_gnt, bus.mem_req, bus.mem_we, bus.p0_stall, bus.p0_rvalid, bus.p1_rvalid};
    n_cmp++;
    if ({ctl, bus.p1_rdata} !== {7'b0, 32'h0}) begin
      n_bad++; $display("FAIL discard_in_reset: got %b %h want 0 0", ctl, bus.p1_rdata);
    end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if ({bus.p0_rvalid, bus.p1_rvalid} !== 2'b00) begin
        n_bad++; $display("FAIL discard_after%0d: got %b want 00", i, {bus.p0_rvalid, bus.p1_rvalid});
      end
      next_cycle();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_policy();
`ifndef DMEM_ARB_RR_EN
    test_idle_hold();
`endif
    test_lock_burst();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
